scroll_display_ctrl: RTL and testbench
======================================

Name: scroll_display_ctrl

Overview:
- Sequences the 4-digit multiplexed 7-segment display and the scroll position of the stored message.
- Owns the refresh schedule (one active anode at a time, with blanking dead-time), the message-memory read port, and the scroll offset.
- The offset advances on a debounced step pulse or on an automatic scroll tick, and only at a frame boundary.
- Runs in the 5 MHz divided clock domain, between the message memory and the LED decoder.

Parameters:
MSG_LEN, 16, message length in characters; legal range 4..16.
REFRESH_DIV, 1250, clock cycles per digit slot; must be greater than BLANK_CYC.
BLANK_CYC, 4, cycles at the start of each slot with all anodes off; must be at least 2.
SCROLL_DIV, 1250000, clock cycles per automatic scroll tick (0.25 s at 5 MHz).

Ports:
clk  in  1  system clock; the design's single clock domain.
reset  in  1  asynchronous, active-high reset.
auto_en  in  1  level input; 1 enables automatic scrolling.
step  in  1  single-cycle pulse from the debouncer; requests one scroll advance.
mem_addr  out  4  message-memory read address.
mem_data  in  4  character code; valid one cycle after mem_addr.
an  out  4  active-low anodes; an[3] is the leftmost digit.
char  out  4  character code to the LED decoder.
offset  out  4  current scroll offset, 0..MSG_LEN-1.

Behaviour:
- Reset (asynchronous, takes effect immediately without a clock edge):
  - an=4'b1111, char=0, mem_addr=0, offset=0.
  - Digit index d=3, slot counter=0, tick counter=0, pending=0, FSM=FETCH.
- Digit order is d=3,2,1,0, then repeats. One slot is REFRESH_DIV cycles; one frame is 4*REFRESH_DIV cycles.
- Per-slot FSM, indexed by slot cycle s:
  - FETCH (s=0): mem_addr=(offset+(3-d)) mod MSG_LEN; an=1111.
  - LATCH (s=1): char is registered from mem_data; char is valid from s=2; an=1111.
  - BLANK (s=2..BLANK_CYC-1): an=1111. Skipped when BLANK_CYC=2.
  - SHOW (s=BLANK_CYC..REFRESH_DIV-1): an[d]=0, other anodes 1; char held stable.
  - At s=REFRESH_DIV-1: the next state is FETCH, d decrements, and 0 wraps to 3.
- At most one anode is low in any cycle. No anode is low while char is changing.
- Address wrap: offset+k with k in 0..3 is reduced by a single compare-subtract against MSG_LEN. No modulo operator.
- Tick counter:
  - Counts 0..SCROLL_DIV-1 while auto_en=1.
  - Reaching SCROLL_DIV-1 raises a one-cycle tick and wraps to 0.
  - Held at 0 while auto_en=0.
- Scroll event = step OR tick. step is accepted in both modes.
- Pending flag:
  - Set by an event.
  - Multiple events within one frame collapse to a single advance.
- Frame boundary is the last cycle of the d=0 slot. At that cycle, if pending or an event occurs:
  - offset <= offset+1, wrapping MSG_LEN-1 to 0.
  - pending <= 0.
  - An event in the boundary cycle itself is consumed by that boundary.
- The offset never changes mid-frame, so all 4 digits of a frame show one consistent window.
- Latency: a step is reflected on the display from the first slot of the frame after the next frame boundary, i.e. at most 1 frame plus 1 slot.
- A reset asserted mid-slot blanks all anodes immediately and discards pending.

Test Plan (REFRESH_DIV=8, BLANK_CYC=2, SCROLL_DIV=40; the memory model returns data=addr):
1. Release reset with auto_en=0:
   - Slot 0: an=1111 for 2 cycles, then 0111 for 6 cycles with char=0.
   - Following slots: 1011 with char=1, 1101 with char=2, 1110 with char=3.
   - Frame repeats every 32 cycles; offset stays 0.
2. step pulse at cycle 10 of a frame:
   - offset stays 0 through cycle 31 and becomes 1 at the boundary.
   - Next frame shows chars 1,2,3,4.
3. Two step pulses in one frame, plus one pulse exactly in the boundary cycle of the following frame:
   - offset goes 0→1 at the first boundary.
   - offset goes 1→2 at the second boundary.
4. auto_en=1 for 8 ticks (320 cycles), no step:
   - Each tick advances offset exactly once at the next boundary; offset=8 afterwards.
   - Drop auto_en: tick counter returns to 0 and offset holds.
5. Wrap:
   - MSG_LEN=16, offset=13: chars shown are 13,14,15,0.
   - MSG_LEN=12, offset=11: chars shown are 11,0,1,2; the step after that gives offset=0.
6. Assert reset asynchronously while an=1011 with pending=1:
   - an=1111 before the next clk edge.
   - After release: offset=0, pending cleared, sequence restarts as in scenario 1.

Source files
------------

// File: rtl/scroll_display_ctrl.sv
// Refresh sequencer for a 4-digit multiplexed 7-segment display, with a scroll offset
// into the stored message that only moves at frame boundaries.
module scroll_display_ctrl #(
    parameter int unsigned MSG_LEN     = 16,
    parameter int unsigned REFRESH_DIV = 1250,
    parameter int unsigned BLANK_CYC   = 4,
    parameter int unsigned SCROLL_DIV  = 1250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       auto_en,
    input  logic       step,
    output logic [3:0] mem_addr,
    input  logic [3:0] mem_data,
    output logic [3:0] an,
    output logic [3:0] char,
    output logic [3:0] offset
);

    localparam int unsigned SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned TICK_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SCROLL_DIV - 1);
    localparam logic [4:0]        LEN        = 5'(MSG_LEN);
    localparam logic [3:0]        OFF_LAST   = 4'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LATCH = 2'd1,
        BLANK = 2'd2,
        SHOW  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [1:0]          digit_q, digit_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                pending_q, pending_d;
    logic [3:0]          offset_d;
    logic [3:0]          mem_addr_d;
    logic [3:0]          an_d;
    logic [3:0]          char_d;
    logic                last_slot;
    logic                frame_end;
    logic                tick_c;
    logic                scroll_evt;

    // Single compare-subtract reduction of offset+k into 0..MSG_LEN-1.
    function automatic logic [3:0] wrap_addr(input logic [3:0] off, input logic [1:0] k);
        logic [4:0] sum;
        sum = {1'b0, off} + {3'b000, k};
        if (sum >= LEN) begin
            sum = sum - LEN;
        end
        return sum[3:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            slot_q    <= '0;
            digit_q   <= 2'd3;
            tick_q    <= '0;
            pending_q <= 1'b0;
            offset    <= 4'd0;
            mem_addr  <= 4'd0;
            an        <= 4'hF;
            char      <= 4'd0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            digit_q   <= digit_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
            offset    <= offset_d;
            mem_addr  <= mem_addr_d;
            an        <= an_d;
            char      <= char_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q + SLOT_W'(1);
        digit_d    = digit_q;
        tick_d     = tick_q;
        tick_c     = 1'b0;
        pending_d  = pending_q;
        offset_d   = offset;
        mem_addr_d = mem_addr;
        an_d       = 4'hF;
        char_d     = char;

        last_slot  = (slot_q == SLOT_LAST);
        frame_end  = last_slot && (digit_q == 2'd0);

        // Auto-scroll tick generator, parked at zero while disabled.
        if (!auto_en) begin
            tick_d = '0;
        end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            tick_c = 1'b1;
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end

        scroll_evt = step | tick_c;

        // Offset only moves on the frame boundary, so a frame shows one window.
        if (frame_end) begin
            if (pending_q || scroll_evt) begin
                offset_d = (offset == OFF_LAST) ? 4'd0 : offset + 4'd1;
            end
            pending_d = 1'b0;
        end else if (scroll_evt) begin
            pending_d = 1'b1;
        end

        if (last_slot) begin
            slot_d  = '0;
            digit_d = digit_q - 2'd1;
        end

        case (state_q)
            FETCH:   state_d = LATCH;
            LATCH:   state_d = (BLANK_CYC > 2) ? BLANK : SHOW;
            BLANK:   if (slot_q == BLANK_LAST) state_d = SHOW;
            SHOW:    if (last_slot) state_d = FETCH;
            default: state_d = FETCH;
        endcase

        // Address for the next slot uses the post-boundary offset.
        if (last_slot) begin
            mem_addr_d = wrap_addr(offset_d, ~digit_d);
        end

        if (state_q == LATCH) begin
            char_d = mem_data;
        end

        if (state_d == SHOW) begin
            an_d = ~(4'b0001 << digit_d);
        end
    end

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Self-checking bench: two instances (MSG_LEN 16 and 12) against a cycle-count based model.
module tb_scroll_display_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int SD = 40;
    localparam int FR = 4 * RD;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       auto_en = 1'b0;
    logic       step    = 1'b0;
    logic [3:0] addr16, data16, an16, char16, off16;
    logic [3:0] addr12, data12, an12, char12, off12;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cycles since reset, offsets for both lengths, pending, tick count.
    int m_cyc   = 0;
    int m_off16 = 0;
    int m_off12 = 0;
    int m_tcnt  = 0;
    bit m_pend  = 1'b0;

    always #5 clk = ~clk;

    scroll_display_ctrl #(.MSG_LEN(16), .REFRESH_DIV(RD), .BLANK_CYC(BC), .SCROLL_DIV(SD)) dut16 (
        .clk(clk), .reset(reset), .auto_en(auto_en), .step(step),
        .mem_addr(addr16), .mem_data(data16), .an(an16), .char(char16), .offset(off16)
    );

    scroll_display_ctrl #(.MSG_LEN(12), .REFRESH_DIV(RD), .BLANK_CYC(BC), .SCROLL_DIV(SD)) dut12 (
        .clk(clk), .reset(reset), .auto_en(auto_en), .step(step),
        .mem_addr(addr12), .mem_data(data12), .an(an12), .char(char12), .offset(off12)
    );

    // Message memories return data equal to the address, one cycle later.
    always @(posedge clk) begin
        data16 <= addr16;
        data12 <= addr12;
    end

    function automatic logic [3:0] exp_an(input int cyc);
        int s = cyc % RD;
        int d = 3 - (cyc / RD) % 4;
        if (s < BC) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    function automatic int exp_char(input int cyc, input int off, input int len);
        int d = 3 - (cyc / RD) % 4;
        return (off + 3 - d) % len;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_off16 = 0; m_off12 = 0; m_tcnt = 0; m_pend = 1'b0;
    endtask

    task automatic model_step(input logic stp, input logic ae);
        bit tk;
        tk = 1'b0;
        if (!ae) m_tcnt = 0;
        else if (m_tcnt == SD - 1) begin m_tcnt = 0; tk = 1'b1; end
        else m_tcnt++;
        if (m_cyc % FR == FR - 1) begin
            if (m_pend || stp || tk) begin
                m_off16 = (m_off16 + 1) % 16;
                m_off12 = (m_off12 + 1) % 12;
            end
            m_pend = 1'b0;
        end else if (stp || tk) begin
            m_pend = 1'b1;
        end
        m_cyc++;
    endtask

    // Drive one cycle from a negedge; returns on the following negedge.
    task automatic drive(input logic stp, input logic ae);
        step = stp;
        auto_en = ae;
        @(posedge clk);
        model_step(stp, ae);
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic wait_pos(input int pos, input logic ae);
        int n = 0;
        while ((m_cyc % FR) != pos && n < 2 * FR) begin
            drive(1'b0, ae);
            n++;
        end
        if ((m_cyc % FR) != pos) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_pos got=%0d required=%0d", m_cyc % FR, pos);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (an16 !== 4'hF) begin n_bad++; $display("FAIL reset_an16 got=%b required=1111", an16); end
        n_cmp++; if (an12 !== 4'hF) begin n_bad++; $display("FAIL reset_an12 got=%b required=1111", an12); end
        n_cmp++; if (char16 !== 4'd0) begin n_bad++; $display("FAIL reset_char got=%0d required=0", char16); end
        n_cmp++; if (addr16 !== 4'd0) begin n_bad++; $display("FAIL reset_addr got=%0d required=0", addr16); end
        n_cmp++; if (off16 !== 4'd0) begin n_bad++; $display("FAIL reset_offset got=%0d required=0", off16); end
        n_cmp++; if (off12 !== 4'd0) begin n_bad++; $display("FAIL reset_offset12 got=%0d required=0", off12); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_refresh();
        for (int i = 0; i < 2 * FR; i++) begin
            int s = m_cyc % RD;
            n_cmp++; if (an16 !== exp_an(m_cyc)) begin n_bad++; $display("FAIL refresh_an16 cyc=%0d got=%b required=%b", m_cyc, an16, exp_an(m_cyc)); end
            n_cmp++; if (an12 !== exp_an(m_cyc)) begin n_bad++; $display("FAIL refresh_an12 cyc=%0d got=%b required=%b", m_cyc, an12, exp_an(m_cyc)); end
            n_cmp++; if (off16 !== 4'd0) begin n_bad++; $display("FAIL refresh_offset cyc=%0d got=%0d required=0", m_cyc, off16); end
            if (s >= BC) begin
                n_cmp++;
                if (char16 !== 4'(exp_char(m_cyc, 0, 16))) begin
                    n_bad++; $display("FAIL refresh_char cyc=%0d got=%0d required=%0d", m_cyc, char16, exp_char(m_cyc, 0, 16));
                end
            end
            if (s == 0) begin
                n_cmp++;
                if (addr16 !== 4'(exp_char(m_cyc, 0, 16))) begin
                    n_bad++; $display("FAIL refresh_addr cyc=%0d got=%0d required=%0d", m_cyc, addr16, exp_char(m_cyc, 0, 16));
                end
            end
            drive(1'b0, 1'b0);
        end
    endtask

    task automatic test_step();
        logic [3:0] got [4];
        wait_pos(10, 1'b0);
        drive(1'b1, 1'b0);
        while (m_cyc % FR != 0) begin
            n_cmp++; if (off16 !== 4'd0) begin n_bad++; $display("FAIL step_hold cyc=%0d got=%0d required=0", m_cyc, off16); end
            drive(1'b0, 1'b0);
        end
        n_cmp++; if (off16 !== 4'd1) begin n_bad++; $display("FAIL step_advance got=%0d required=1", off16); end
        for (int i = 0; i < FR; i++) begin
            if (i % RD == 4) got[i / RD] = char16;
            drive(1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (got[k] !== 4'(k + 1)) begin n_bad++; $display("FAIL step_window slot=%0d got=%0d required=%0d", k, got[k], k + 1); end
        end
    endtask

    task automatic test_multi();
        wait_pos(0, 1'b0);
        for (int i = 0; i < 3 * FR; i++) begin
            n_cmp++; if (off16 !== 4'(m_off16)) begin n_bad++; $display("FAIL multi_offset cyc=%0d got=%0d required=%0d", m_cyc, off16, m_off16); end
            if (i == FR) begin
                n_cmp++; if (off16 !== 4'd2) begin n_bad++; $display("FAIL multi_first got=%0d required=2", off16); end
            end
            if (i == 2 * FR) begin
                n_cmp++; if (off16 !== 4'd3) begin n_bad++; $display("FAIL multi_boundary got=%0d required=3", off16); end
            end
            drive(i == 3 || i == 20 || i == 2 * FR - 1, 1'b0);
        end
        n_cmp++; if (off16 !== 4'd3) begin n_bad++; $display("FAIL multi_settle got=%0d required=3", off16); end
        n_cmp++; if (off12 !== 4'd3) begin n_bad++; $display("FAIL multi_settle12 got=%0d required=3", off12); end
    endtask

    task automatic test_auto();
        for (int i = 0; i < 320 + 2 * FR; i++) begin
            n_cmp++; if (off16 !== 4'(m_off16)) begin n_bad++; $display("FAIL auto_offset cyc=%0d got=%0d required=%0d", m_cyc, off16, m_off16); end
            drive(1'b0, i < 320);
        end
        n_cmp++; if (off16 !== 4'd11) begin n_bad++; $display("FAIL auto_total got=%0d required=11", off16); end
        n_cmp++; if (off12 !== 4'd11) begin n_bad++; $display("FAIL auto_total12 got=%0d required=11", off12); end
    endtask

    task automatic test_wrap();
        logic [3:0] got [4];
        int exp12 [4] = '{11, 0, 1, 2};
        int exp16 [4] = '{13, 14, 15, 0};
        wait_pos(0, 1'b0);
        for (int i = 0; i < FR; i++) begin
            if (i % RD == 4) got[i / RD] = char12;
            drive(1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (got[k] !== 4'(exp12[k])) begin n_bad++; $display("FAIL wrap12_window slot=%0d got=%0d required=%0d", k, got[k], exp12[k]); end
        end
        wait_pos(10, 1'b0);
        drive(1'b1, 1'b0);
        wait_pos(0, 1'b0);
        n_cmp++; if (off12 !== 4'd0) begin n_bad++; $display("FAIL wrap12_offset got=%0d required=0", off12); end
        wait_pos(10, 1'b0);
        drive(1'b1, 1'b0);
        wait_pos(0, 1'b0);
        n_cmp++; if (off16 !== 4'd13) begin n_bad++; $display("FAIL wrap16_offset got=%0d required=13", off16); end
        for (int i = 0; i < FR; i++) begin
            if (i % RD == 4) got[i / RD] = char16;
            if (i % RD == 0) begin
                n_cmp++;
                if (addr16 !== 4'(exp16[i / RD])) begin n_bad++; $display("FAIL wrap16_addr slot=%0d got=%0d required=%0d", i / RD, addr16, exp16[i / RD]); end
            end
            drive(1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (got[k] !== 4'(exp16[k])) begin n_bad++; $display("FAIL wrap16_window slot=%0d got=%0d required=%0d", k, got[k], exp16[k]); end
        end
    endtask

    task automatic test_random();
        logic ae = 1'b0;
        for (int i = 0; i < 1600; i++) begin
            int s = m_cyc % RD;
            if ($urandom_range(0, 99) == 0) ae = ~ae;
            n_cmp++; if (an16 !== exp_an(m_cyc)) begin n_bad++; $display("FAIL rand_an cyc=%0d got=%b required=%b", m_cyc, an16, exp_an(m_cyc)); end
            n_cmp++; if (off16 !== 4'(m_off16)) begin n_bad++; $display("FAIL rand_offset16 cyc=%0d got=%0d required=%0d", m_cyc, off16, m_off16); end
            n_cmp++; if (off12 !== 4'(m_off12)) begin n_bad++; $display("FAIL rand_offset12 cyc=%0d got=%0d required=%0d", m_cyc, off12, m_off12); end
            if (s >= BC) begin
                n_cmp++;
                if (char16 !== 4'(exp_char(m_cyc, m_off16, 16))) begin
                    n_bad++; $display("FAIL rand_char16 cyc=%0d got=%0d required=%0d", m_cyc, char16, exp_char(m_cyc, m_off16, 16));
                end
                n_cmp++;
                if (char12 !== 4'(exp_char(m_cyc, m_off12, 12))) begin
                    n_bad++; $display("FAIL rand_char12 cyc=%0d got=%0d required=%0d", m_cyc, char12, exp_char(m_cyc, m_off12, 12));
                end
            end
            if (s == 0) begin
                n_cmp++;
                if (addr12 !== 4'(exp_char(m_cyc, m_off12, 12))) begin
                    n_bad++; $display("FAIL rand_addr12 cyc=%0d got=%0d required=%0d", m_cyc, addr12, exp_char(m_cyc, m_off12, 12));
                end
            end
            drive($urandom_range(0, 9) == 0, ae);
        end
    endtask

    task automatic test_async_reset();
        wait_pos(0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        wait_pos(12, 1'b0);
        n_cmp++; if (an16 !== 4'b1011) begin n_bad++; $display("FAIL arst_pre_an got=%b required=1011", an16); end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (an16 !== 4'hF) begin n_bad++; $display("FAIL arst_an16 got=%b required=1111", an16); end
        n_cmp++; if (an12 !== 4'hF) begin n_bad++; $display("FAIL arst_an12 got=%b required=1111", an12); end
        n_cmp++; if (off16 !== 4'd0) begin n_bad++; $display("FAIL arst_offset got=%0d required=0", off16); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < FR + RD; i++) begin
            int s = m_cyc % RD;
            n_cmp++; if (an16 !== exp_an(m_cyc)) begin n_bad++; $display("FAIL arst_seq_an cyc=%0d got=%b required=%b", m_cyc, an16, exp_an(m_cyc)); end
            n_cmp++; if (off16 !== 4'd0) begin n_bad++; $display("FAIL arst_pending cyc=%0d got=%0d required=0", m_cyc, off16); end
            if (s >= BC) begin
                n_cmp++;
                if (char16 !== 4'(exp_char(m_cyc, 0, 16))) begin
                    n_bad++; $display("FAIL arst_char cyc=%0d got=%0d required=%0d", m_cyc, char16, exp_char(m_cyc, 0, 16));
                end
            end
            drive(1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_refresh();
        test_step();
        test_multi();
        test_auto();
        test_wrap();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
